// File: rtl/ascon_round_sequencer_if.sv
// ============================================================================
//  Module      : ascon_round_sequencer_if
//  Description : Handshake and status bundle between the ASCON top-level FSM
//                (master) and the round sequencer (slave).
//                Optional macro ASCON_ROUND_CONST_OUT_EN adds rc_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_round_sequencer_if #(
  parameter int CPT_W  = 4
`ifdef ASCON_ROUND_CONST_OUT_EN
  ,
  parameter int UNROLL = 1
`endif
);
  logic             start_i;
  logic [1:0]       mode_i;
  logic             stall_i;
  logic             abort_i;
  logic             busy_o;
  logic [CPT_W-1:0] cpt_o;
  logic             first_round_o;
  logic             last_round_o;
  logic             done_o;
  logic             err_o;
`ifdef ASCON_ROUND_CONST_OUT_EN
  logic [8*UNROLL-1:0] rc_o;
`endif

  modport master (
    output start_i, mode_i, stall_i, abort_i,
`ifdef ASCON_ROUND_CONST_OUT_EN
    input  rc_o,
`endif
    input  busy_o, cpt_o, first_round_o, last_round_o, done_o, err_o
  );

  modport slave (
    input  start_i, mode_i, stall_i, abort_i,
`ifdef ASCON_ROUND_CONST_OUT_EN
    output rc_o,
`endif
    output busy_o, cpt_o, first_round_o, last_round_o, done_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/ascon_round_sequencer.sv
// ============================================================================
//  Module      : ascon_round_sequencer
//  Description : Sequences p^a / p^b / p^c permutation rounds with optional
//                unrolling, start/busy/done handshake, stall and abort.
//                Optional macro ASCON_ROUND_CONST_OUT_EN adds registered
//                round-constant bytes (rc_o) for each unrolled round.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_round_sequencer #(
  parameter int CPT_W        = 4,
  parameter int TOTAL_ROUNDS = 12,
  parameter int ROUNDS_A     = 12,
  parameter int ROUNDS_B     = 8,
  parameter int ROUNDS_C     = 6,
  parameter int UNROLL       = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  ascon_round_sequencer_if.slave bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [CPT_W-1:0] c_idx_a    = CPT_W'(TOTAL_ROUNDS - ROUNDS_A);
  localparam logic [CPT_W-1:0] c_idx_b    = CPT_W'(TOTAL_ROUNDS - ROUNDS_B);
  localparam logic [CPT_W-1:0] c_idx_c    = CPT_W'(TOTAL_ROUNDS - ROUNDS_C);
  localparam logic [CPT_W-1:0] c_last_idx = CPT_W'(TOTAL_ROUNDS - UNROLL);
  localparam logic [CPT_W-1:0] c_step     = CPT_W'(UNROLL);

  // Parameter sanity: bad combinations must never reach silicon.
  if (UNROLL < 1 || UNROLL > 3) begin : g_chk_unroll
    $fatal(1, "UNROLL must be 1, 2 or 3");
  end
  if (TOTAL_ROUNDS >= (1 << CPT_W)) begin : g_chk_width
    $fatal(1, "TOTAL_ROUNDS does not fit in CPT_W bits");
  end
  if (ROUNDS_A > TOTAL_ROUNDS || ROUNDS_A < UNROLL || (ROUNDS_A % UNROLL) != 0) begin : g_chk_a
    $fatal(1, "ROUNDS_A illegal for TOTAL_ROUNDS/UNROLL");
  end
  if (ROUNDS_B > TOTAL_ROUNDS || ROUNDS_B < UNROLL || (ROUNDS_B % UNROLL) != 0) begin : g_chk_b
    $fatal(1, "ROUNDS_B illegal for TOTAL_ROUNDS/UNROLL");
  end
  if (ROUNDS_C > TOTAL_ROUNDS || ROUNDS_C < UNROLL || (ROUNDS_C % UNROLL) != 0) begin : g_chk_c
    $fatal(1, "ROUNDS_C illegal for TOTAL_ROUNDS/UNROLL");
  end

  logic [1:0]       r_state, w_state_next;
  logic [CPT_W-1:0] r_cpt, w_cpt_next;
  logic [CPT_W-1:0] r_start_idx, w_start_idx_next;
  logic             r_err, w_err_next;
  logic             w_mode_ok;
  logic [CPT_W-1:0] w_sel_idx;

  // Decode the requested mode into its first round index.
  always_comb begin
    w_mode_ok = (bus.mode_i != 2'b11);
    case (bus.mode_i)
      2'b00:   w_sel_idx = c_idx_a;
      2'b01:   w_sel_idx = c_idx_b;
      default: w_sel_idx = c_idx_c;
    endcase
  end

  // State, index and error-pulse registers; reset wins over everything.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= c_st_idle;
      r_cpt       <= '0;
      r_start_idx <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cpt       <= w_cpt_next;
      r_start_idx <= w_start_idx_next;
      r_err       <= w_err_next;
    end
  end

  // Next-state and next-index logic; abort beats stall beats progress.
  always_comb begin
    w_state_next     = r_state;
    w_cpt_next       = r_cpt;
    w_start_idx_next = r_start_idx;
    w_err_next       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (bus.start_i) begin
          if (w_mode_ok) begin
            w_state_next     = c_st_run;
            w_cpt_next       = w_sel_idx;
            w_start_idx_next = w_sel_idx;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      c_st_run: begin
        if (bus.abort_i) begin
          w_state_next = c_st_idle;
          w_cpt_next   = '0;
        end else if (!bus.stall_i) begin
          if (r_cpt == c_last_idx) begin
            w_state_next = c_st_done;
          end else begin
            w_cpt_next = r_cpt + c_step;
          end
        end
      end
      c_st_done: begin
        if (bus.start_i && w_mode_ok) begin
          w_state_next     = c_st_run;
          w_cpt_next       = w_sel_idx;
          w_start_idx_next = w_sel_idx;
        end else begin
          w_state_next = c_st_idle;
          w_cpt_next   = '0;
          w_err_next   = bus.start_i;
        end
      end
      default: begin
        w_state_next = c_st_idle;
        w_cpt_next   = '0;
      end
    endcase
  end

  // Status outputs decoded from the registered state and index.
  always_comb begin
    bus.busy_o        = (r_state == c_st_run);
    bus.done_o        = (r_state == c_st_done);
    bus.first_round_o = (r_state == c_st_run) && (r_cpt == r_start_idx);
    bus.last_round_o  = (r_state == c_st_run) && (r_cpt == c_last_idx);
    bus.cpt_o         = r_cpt;
    bus.err_o         = r_err;
  end

`ifdef ASCON_ROUND_CONST_OUT_EN
  logic [8*UNROLL-1:0] r_rc;
  logic [8*UNROLL-1:0] w_rc_next;

  // One constant byte per unrolled round, computed from the next index so
  // it lands in the same cycle as cpt_o.
  for (genvar k = 0; k < UNROLL; k++) begin : g_rc
    logic [CPT_W-1:0] w_idx;
    logic [3:0]       w_nib;
    assign w_idx = w_cpt_next + CPT_W'(k);
    assign w_nib = 4'(w_idx);
    assign w_rc_next[8*k +: 8] = (w_state_next == c_st_run) ? {4'hF - w_nib, w_nib} : 8'h00;
  end

  // Round-constant register, cleared outside RUN.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_rc <= '0;
    end else begin
      r_rc <= w_rc_next;
    end
  end

  assign bus.rc_o = r_rc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ascon_round_sequencer.sv
// ============================================================================
//  Module      : tb_ascon_round_sequencer
//  Description : Directed self-checking bench; one DUT with UNROLL=1 and one
//                with UNROLL=2 share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_round_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       stall;
  logic       abort;
  int         n_cmp;
  int         n_err;

`ifdef ASCON_ROUND_CONST_OUT_EN
  ascon_round_sequencer_if #(.CPT_W(4), .UNROLL(1)) u_if1 ();
  ascon_round_sequencer_if #(.CPT_W(4), .UNROLL(2)) u_if2 ();
`else
  ascon_round_sequencer_if #(.CPT_W(4)) u_if1 ();
  ascon_round_sequencer_if #(.CPT_W(4)) u_if2 ();
`endif

  assign u_if1.start_i = start;
  assign u_if1.mode_i  = mode;
  assign u_if1.stall_i = stall;
  assign u_if1.abort_i = abort;
  assign u_if2.start_i = start;
  assign u_if2.mode_i  = mode;
  assign u_if2.stall_i = stall;
  assign u_if2.abort_i = abort;

  ascon_round_sequencer #(
    .CPT_W(4), .TOTAL_ROUNDS(12), .ROUNDS_A(12), .ROUNDS_B(8), .ROUNDS_C(6), .UNROLL(1)
  ) u_dut1 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (u_if1.slave)
  );

  ascon_round_sequencer #(
    .CPT_W(4), .TOTAL_ROUNDS(12), .ROUNDS_A(12), .ROUNDS_B(8), .ROUNDS_C(6), .UNROLL(2)
  ) u_dut2 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (u_if2.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_cpt;
    logic        saw_done;
    clk   = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    stall = 1'b0;
    abort = 1'b0;
    n_cmp = 0;
    n_err = 0;

    // Reset values
    tick();
    tick();
    chk("rst_cpt",   32'(u_if1.cpt_o), 0);
    chk("rst_busy",  32'(u_if1.busy_o), 0);
    chk("rst_first", 32'(u_if1.first_round_o), 0);
    chk("rst_last",  32'(u_if1.last_round_o), 0);
    chk("rst_done",  32'(u_if1.done_o), 0);
    chk("rst_err",   32'(u_if1.err_o), 0);
    rst = 1'b0;
    tick();

    // Mode A, UNROLL=1: cpt 0..11 on cycles 1..12, done at 13
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk("a_cpt",   32'(u_if1.cpt_o), 32'(c - 1));
      chk("a_busy",  32'(u_if1.busy_o), 1);
      chk("a_first", 32'(u_if1.first_round_o), (c == 1) ? 1 : 0);
      chk("a_last",  32'(u_if1.last_round_o), (c == 12) ? 1 : 0);
      chk("a_done",  32'(u_if1.done_o), 0);
`ifdef ASCON_ROUND_CONST_OUT_EN
      if (c == 1)  chk("a_rc0",  32'(u_if1.rc_o), 32'h0F0);
      if (c == 7)  chk("a_rc6",  32'(u_if1.rc_o), 32'h096);
      if (c == 12) chk("a_rc11", 32'(u_if1.rc_o), 32'h04B);
`endif
      tick();
    end
    chk("a_done13", 32'(u_if1.done_o), 1);
    chk("a_busy13", 32'(u_if1.busy_o), 0);
    chk("a_cpt13",  32'(u_if1.cpt_o), 11);
`ifdef ASCON_ROUND_CONST_OUT_EN
    chk("a_rc13", 32'(u_if1.rc_o), 0);
`endif
    tick();
    chk("a_done14", 32'(u_if1.done_o), 0);
    chk("a_cpt14",  32'(u_if1.cpt_o), 0);

    // Mode B, back-to-back restart from DONE
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("b_cpt",   32'(u_if1.cpt_o), 32'(c + 3));
      chk("b_first", 32'(u_if1.first_round_o), (c == 1) ? 1 : 0);
      chk("b_last",  32'(u_if1.last_round_o), (c == 8) ? 1 : 0);
      tick();
    end
    chk("b_done9", 32'(u_if1.done_o), 1);
    chk("b_cpt9",  32'(u_if1.cpt_o), 11);
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0;
    chk("b2b_cpt",   32'(u_if1.cpt_o), 4);
    chk("b2b_busy",  32'(u_if1.busy_o), 1);
    chk("b2b_first", 32'(u_if1.first_round_o), 1);
    chk("b2b_done",  32'(u_if1.done_o), 0);

    // Start while RUN (reserved mode) is ignored: no err, progress continues
    start = 1'b1; mode = 2'b11;
    tick();
    start = 1'b0;
    tick();
    chk("run_start_err", 32'(u_if1.err_o), 0);
    chk("run_start_cpt", 32'(u_if1.cpt_o), 6);

    // Mode C with UNROLL=2: cpt 6, 8, 10, done at 4
    do_reset();
    start = 1'b1; mode = 2'b10;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("c2_cpt",   32'(u_if2.cpt_o), 32'(4 + 2 * c));
      chk("c2_first", 32'(u_if2.first_round_o), (c == 1) ? 1 : 0);
      chk("c2_last",  32'(u_if2.last_round_o), (c == 3) ? 1 : 0);
      chk("c2_busy",  32'(u_if2.busy_o), 1);
      tick();
    end
    chk("c2_done4", 32'(u_if2.done_o), 1);
    chk("c2_busy4", 32'(u_if2.busy_o), 0);
`ifdef ASCON_ROUND_CONST_OUT_EN
    chk("c2_rc4", 32'(u_if2.rc_o), 0);
`endif

    // Stall at cycles 3-5 of a mode A run: cpt holds 2 through cycle 6, done at 16
    do_reset();
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      stall = (c >= 3 && c <= 5);
      exp_cpt = (c <= 3) ? 32'(c - 1) : ((c <= 6) ? 32'd2 : 32'(c - 4));
      chk("st_cpt",  32'(u_if1.cpt_o), exp_cpt);
      chk("st_last", 32'(u_if1.last_round_o), (c == 15) ? 1 : 0);
      chk("st_done", 32'(u_if1.done_o), 0);
      tick();
    end
    stall = 1'b0;
    chk("st_done16", 32'(u_if1.done_o), 1);

    // Abort at cycle 7: IDLE with cpt 0 at 8, done never
    do_reset();
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    chk("ab_cpt7", 32'(u_if1.cpt_o), 6);
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    chk("ab_cpt8",  32'(u_if1.cpt_o), 0);
    chk("ab_busy8", 32'(u_if1.busy_o), 0);
    saw_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      saw_done = saw_done | u_if1.done_o;
      tick();
    end
    chk("ab_no_done", 32'(saw_done), 0);

    // Reserved mode: one-cycle err pulse, busy stays low
    start = 1'b1; mode = 2'b11;
    tick();
    start = 1'b0;
    chk("rsv_err",   32'(u_if1.err_o), 1);
    chk("rsv_busy",  32'(u_if1.busy_o), 0);
    tick();
    chk("rsv_err2",  32'(u_if1.err_o), 0);
    chk("rsv_busy2", 32'(u_if1.busy_o), 0);

    // Reset at cycle 5 of a run: all outputs zero at cycle 6
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    chk("mr_cpt5", 32'(u_if1.cpt_o), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_cpt",   32'(u_if1.cpt_o), 0);
    chk("mr_busy",  32'(u_if1.busy_o), 0);
    chk("mr_first", 32'(u_if1.first_round_o), 0);
    chk("mr_last",  32'(u_if1.last_round_o), 0);
    chk("mr_done",  32'(u_if1.done_o), 0);
    chk("mr_err",   32'(u_if1.err_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
